timer_scheduler: RTL and testbench
==================================

# timer_scheduler

Shares one tick prescaler and one time-multiplexed decrementer among NT independent countdown timers used by the UI: ring cadence, keypad timeouts and display blink. A prescaler generates a one-cycle tick every TICK_DIV clocks. On each tick a scan FSM visits every timer slot in turn, decrements active counters, and raises per-timer expiry pulses. Host logic starts, restarts and stops timers through per-timer strobes.

## Interface
Parameters:
- NT, 4: number of timer slots (2..16)
- TICK_DIV, 27000: clocks per tick (1 ms at 27 MHz); must be ≥ NT+2
- PW, 15: prescaler counter width; must satisfy 2^PW > TICK_DIV-1
- CW, 16: timer count width

Ports:
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high
- start  in  NT  per-timer start/restart strobe
- stop  in  NT  per-timer cancel strobe
- periodic  in  NT  mode, sampled on start: 1 = auto-reload, 0 = one-shot
- load_value  in  NT*CW  packed; slot i uses bits [i*CW +: CW]; sampled on start
- active  out  NT  timer running
- expired  out  NT  one-cycle expiry pulse per timer
- tick  out  1  prescaler tick, one cycle wide
- scan_busy  out  1  scan FSM is in SCAN

## Operation
- **Prescaler**
  - Counter loads TICK_DIV-1 on reset and decrements each cycle.
  - At 0 it asserts tick for one cycle and reloads TICK_DIV-1.
  - Tick period is exactly TICK_DIV cycles.
- **Per-slot state:** count[CW], reload[CW], mode bit, active bit.
- **Start i:** if load_value_i ≠ 0, then count_i := reload_i := load_value_i, mode_i := periodic_i, active_i := 1. A start while active restarts the timer. Start with load_value 0 is ignored; the slot is unchanged.
- **Stop i:** active_i := 0; no expiry is generated. Stop on an inactive slot has no effect.
- **Start and stop on the same slot in the same cycle:** stop wins.
- **Scan FSM:** states IDLE and SCAN; idx[clog2(NT)].
  - IDLE → SCAN on tick, with idx := 0.
  - In SCAN, slot idx is processed each cycle, then idx increments.
  - SCAN → IDLE after slot NT-1.
- **Slot processing:** no action if inactive. Otherwise:
  - If count = 1: assert expired_idx (registered). If periodic, count := reload; else active := 0.
  - Else: count := count-1.
- **Host strobe in the same cycle as that slot's scan processing:** the strobe wins, the decrement is discarded, and no expiry is generated.
- **Expiry window:** a timer started with value V expires on the V-th tick after start. Elapsed time from start to expiry lies in ((V-1)·TICK_DIV, V·TICK_DIV] cycles, plus scan offset.
- **Elaboration checks:** TICK_DIV < NT+2, or 2^PW ≤ TICK_DIV-1, is a fatal elaboration error.

## Timing
- **Reset:** active=0, expired=0, tick=0, scan_busy=0; all counts and reloads 0; FSM in IDLE; prescaler loaded TICK_DIV-1.
  - Reset mid-scan aborts the scan; no pending expiry survives.
- **Tick:** with reset deasserted at cycle 0, tick is high at cycles TICK_DIV-1, 2·TICK_DIV-1, …
- **Scan schedule:** for tick high at cycle T:
  - scan_busy is high over cycles T+1 … T+NT.
  - Slot i is processed at cycle T+1+i.
  - expired[i] is high only at cycle T+2+i.
  - On expiry of a one-shot timer, active[i] falls at T+2+i.
- **Host strobes:** start/stop take effect on active at the next cycle (1-cycle latency).
- **Scan overlap:** scans never overlap, because TICK_DIV ≥ NT+2.

## Structure
- **Package timer_pkg:** scan state enum (IDLE, SCAN) and parameter-legality constants/functions (clog2, width checks).
- **Sub-module tick_prescaler:** parameters TICK_DIV and PW; ports clk, reset, tick. It is the only natural split.
- The scan FSM, slot registers and shared decrementer stay in timer_scheduler.

## Test plan
Test parameters: NT=4, TICK_DIV=8, PW=3, CW=8. Reset deasserts at cycle 0.
1. **Idle after reset:** no stimulus → tick at cycles 7, 15, 23; active=0; expired never high; scan_busy high at cycles 8–11.
2. **One-shot:**
   - Stimulus: start[0] with load 3, periodic 0, at cycle 2.
   - Required: active[0] at cycle 3; expired[0] only at cycle 25; active[0] falls at 25.
3. **Periodic, then stop:**
   - Stimulus: start[2] with load 2, periodic 1, at cycle 2.
   - Required: expired[2] at cycles 19, 35, 51.
   - Then stop[2] at cycle 40: active[2]=0 at 41; no pulse at 51 or later.
4. **Edge cases:**
   - start[1]=stop[1]=1 same cycle → active[1] stays 0.
   - start[3] with load 0 → ignored.
   - start[0] restart with load 5 while count=1 → no expiry at the next tick; expires 5 ticks later.
5. **Simultaneous expiry:**
   - Stimulus: all four timers started with load 1 at cycle 2.
   - Required: expired[0..3] at cycles 9, 10, 11, 12 respectively; all active fall.
6. **Reset mid-scan:**
   - Stimulus: reset asserted at cycle 9 with timers armed to expire on the tick at cycle 7.
   - Required: no expired pulse after cycle 9; all outputs 0; tick resumes TICK_DIV-1 cycles after reset release.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and elaboration-time legality helpers for the timer scheduler.
package timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int unsigned p = 1; p < n; p = p << 1) r++;
    return r;
  endfunction

  function automatic int idx_width(input int nt);
    return (nt < 2) ? 1 : clog2(nt);
  endfunction

  // A full scan must finish before the next tick arrives.
  function automatic bit tick_div_ok(input int nt, input int div);
    return div >= nt + 2;
  endfunction

  function automatic bit prescaler_fits(input int pw, input int div);
    return (longint'(1) << pw) > longint'(div - 1);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks.
module tick_prescaler #(
  parameter int TICK_DIV = 27000,
  parameter int PW       = 15
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  logic [PW-1:0] cnt;

  // tick is registered, so it is raised one count early to line up with cnt == 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= PW'(TICK_DIV - 1);
      tick <= 1'b0;
    end else begin
      tick <= (cnt == PW'(1));
      cnt  <= (cnt == '0) ? PW'(TICK_DIV - 1) : cnt - PW'(1);
    end
  end

endmodule

// File: rtl/timer_scheduler.sv
// NT countdown timers sharing one prescaler tick and one time-multiplexed decrementer.
module timer_scheduler
  import timer_pkg::*;
#(
  parameter int NT       = 4,
  parameter int TICK_DIV = 27000,
  parameter int PW       = 15,
  parameter int CW       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NT-1:0]    start,
  input  logic [NT-1:0]    stop,
  input  logic [NT-1:0]    periodic,
  input  logic [NT*CW-1:0] load_value,
  output logic [NT-1:0]    active,
  output logic [NT-1:0]    expired,
  output logic             tick,
  output logic             scan_busy
);

  localparam int IW = idx_width(NT);

  if (!tick_div_ok(NT, TICK_DIV)) begin : g_bad_div
    $fatal(1, "timer_scheduler: TICK_DIV must be at least NT+2");
  end
  if (!prescaler_fits(PW, TICK_DIV)) begin : g_bad_pw
    $fatal(1, "timer_scheduler: PW too narrow for TICK_DIV-1");
  end

  scan_state_t   state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic [CW-1:0] count  [NT];
  logic [CW-1:0] reload [NT];
  logic [NT-1:0] mode;
  logic [NT-1:0] take_start;
  logic [CW-1:0] cur_count, dec_count;
  logic          hit;

  tick_prescaler #(.TICK_DIV(TICK_DIV), .PW(PW)) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    case (state)
      IDLE: if (tick) begin
        state_n = SCAN;
        idx_n   = '0;
      end
      SCAN: begin
        idx_n = idx + IW'(1);
        if (idx == IW'(NT - 1)) begin
          state_n = IDLE;
          idx_n   = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign scan_busy = (state == SCAN);

  // Shared decrementer; a host strobe on the scanned slot cancels that slot's processing.
  always_comb begin
    take_start = '0;
    for (int unsigned i = 0; i < NT; i++)
      take_start[i] = start[i] && (load_value[i*CW +: CW] != '0);
    cur_count = count[idx];
    dec_count = cur_count - CW'(1);
    hit       = (state == SCAN) && active[idx] && !stop[idx] && !take_start[idx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active  <= '0;
      expired <= '0;
      mode    <= '0;
      for (int unsigned i = 0; i < NT; i++) begin
        count[i]  <= '0;
        reload[i] <= '0;
      end
    end else begin
      expired <= '0;
      if (hit) begin
        if (cur_count == CW'(1)) begin
          expired[idx] <= 1'b1;
          if (mode[idx]) count[idx] <= reload[idx];
          else           active[idx] <= 1'b0;
        end else begin
          count[idx] <= dec_count;
        end
      end
      for (int unsigned i = 0; i < NT; i++) begin
        if (stop[i]) begin
          active[i] <= 1'b0;
        end else if (take_start[i]) begin
          count[i]  <= load_value[i*CW +: CW];
          reload[i] <= load_value[i*CW +: CW];
          mode[i]   <= periodic[i];
          active[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_timer_scheduler.sv
// Self-checking bench for timer_scheduler against a cycle-level behavioural model.
module tb_timer_scheduler;

  localparam int NT = 4;
  localparam int TD = 8;
  localparam int PW = 3;
  localparam int CW = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [NT-1:0]    start = '0;
  logic [NT-1:0]    stop = '0;
  logic [NT-1:0]    periodic = '0;
  logic [NT*CW-1:0] load_value = '0;
  logic [NT-1:0]    active, expired;
  logic             tick, scan_busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [NT-1:0] m_act, m_mode, m_exp;
  int            m_left [NT];
  int            m_rel  [NT];

  timer_scheduler #(.NT(NT), .TICK_DIV(TD), .PW(PW), .CW(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .periodic  (periodic),
    .load_value(load_value),
    .active    (active),
    .expired   (expired),
    .tick      (tick),
    .scan_busy (scan_busy)
  );

  always #5 clk = ~clk;

  function automatic logic m_tick();
    return (cyc % TD) == TD - 1;
  endfunction

  function automatic logic m_busy();
    return (cyc >= TD) && ((cyc % TD) < NT);
  endfunction

  // Slot i is visited i+1 cycles after each tick; remaining-tick counts run per slot.
  task automatic model_step();
    logic [NT-1:0] nexp;
    int v;
    nexp = '0;
    for (int i = 0; i < NT; i++) begin
      v = int'(load_value[i*CW +: CW]);
      if (stop[i]) begin
        m_act[i] = 1'b0;
      end else if (start[i] && v != 0) begin
        m_act[i] = 1'b1; m_left[i] = v; m_rel[i] = v; m_mode[i] = periodic[i];
      end else if (m_act[i] && cyc >= TD && (cyc % TD) == i) begin
        if (m_left[i] == 1) begin
          nexp[i] = 1'b1;
          if (m_mode[i]) m_left[i] = m_rel[i];
          else m_act[i] = 1'b0;
        end else begin
          m_left[i] = m_left[i] - 1;
        end
      end
    end
    m_exp = nexp;
  endtask

  task automatic model_clear();
    cyc = 0; m_act = '0; m_mode = '0; m_exp = '0;
    for (int i = 0; i < NT; i++) begin m_left[i] = 0; m_rel[i] = 0; end
  endtask

  task automatic do_reset();
    reset = 1'b1; start = '0; stop = '0; periodic = '0; load_value = '0;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  task automatic advance();
    model_step();
    @(posedge clk); @(negedge clk);
    cyc++;
    start = '0; stop = '0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({active, expired, tick, scan_busy} !== '0) begin
      bad++;
      $display("FAIL reset_state got=%b want=0", {active, expired, tick, scan_busy});
    end
  endtask

  task automatic test_idle();
    do_reset();
    while (cyc < 26) begin
      advance();
      total++;
      if ({active, expired, tick, scan_busy} !== {NT'(0), NT'(0), m_tick(), m_busy()}) begin
        bad++;
        $display("FAIL idle c=%0d got=%b want=%b", cyc, {active, expired, tick, scan_busy},
                 {NT'(0), NT'(0), m_tick(), m_busy()});
      end
    end
  endtask

  task automatic test_oneshot();
    do_reset();
    while (cyc < 30) begin
      if (cyc == 2) begin start[0] = 1'b1; periodic[0] = 1'b0; load_value[0*CW +: CW] = 8'd3; end
      advance();
      total++;
      if ({active, expired, tick, scan_busy} !== {m_act, m_exp, m_tick(), m_busy()}) begin
        bad++;
        $display("FAIL oneshot_model c=%0d got=%b want=%b", cyc,
                 {active, expired, tick, scan_busy}, {m_act, m_exp, m_tick(), m_busy()});
      end
      total++;
      if (expired[0] !== (cyc == 25) || active[0] !== (cyc >= 3 && cyc < 25)) begin
        bad++;
        $display("FAIL oneshot_slot0 c=%0d got act=%b exp=%b want act=%b exp=%b", cyc,
                 active[0], expired[0], (cyc >= 3 && cyc < 25), (cyc == 25));
      end
    end
  endtask

  task automatic test_periodic_stop();
    do_reset();
    while (cyc < 60) begin
      if (cyc == 2) begin start[2] = 1'b1; periodic[2] = 1'b1; load_value[2*CW +: CW] = 8'd2; end
      if (cyc == 40) stop[2] = 1'b1;
      advance();
      total++;
      if ({active, expired} !== {m_act, m_exp}) begin
        bad++;
        $display("FAIL periodic_model c=%0d got=%b want=%b", cyc, {active, expired}, {m_act, m_exp});
      end
      total++;
      if (expired[2] !== (cyc == 19 || cyc == 35) || active[2] !== (cyc >= 3 && cyc < 41)) begin
        bad++;
        $display("FAIL periodic_slot2 c=%0d got act=%b exp=%b", cyc, active[2], expired[2]);
      end
    end
  endtask

  task automatic test_edges();
    do_reset();
    while (cyc < 56) begin
      if (cyc == 2) begin
        start[1] = 1'b1; stop[1] = 1'b1; load_value[1*CW +: CW] = 8'd4;
        start[3] = 1'b1; load_value[3*CW +: CW] = 8'd0;
        start[0] = 1'b1; periodic[0] = 1'b0; load_value[0*CW +: CW] = 8'd2;
      end
      if (cyc == 12) begin start[0] = 1'b1; load_value[0*CW +: CW] = 8'd5; end
      advance();
      total++;
      if ({active, expired} !== {m_act, m_exp}) begin
        bad++;
        $display("FAIL edges_model c=%0d got=%b want=%b", cyc, {active, expired}, {m_act, m_exp});
      end
      total++;
      if (active[1] !== 1'b0 || active[3] !== 1'b0 || expired[0] !== (cyc == 49)) begin
        bad++;
        $display("FAIL edges_fixed c=%0d got act=%b exp=%b want exp0=%b", cyc, active, expired, (cyc == 49));
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [NT-1:0] want;
    do_reset();
    while (cyc < 16) begin
      if (cyc == 2) begin
        start = '1; periodic = '0;
        for (int i = 0; i < NT; i++) load_value[i*CW +: CW] = 8'd1;
      end
      advance();
      want = (cyc >= 9 && cyc <= 12) ? NT'(1 << (cyc - 9)) : NT'(0);
      total++;
      if (expired !== want || (cyc > 12 && active !== '0)) begin
        bad++;
        $display("FAIL simul c=%0d got exp=%b act=%b want exp=%b", cyc, expired, active, want);
      end
    end
  endtask

  task automatic test_reset_midscan();
    do_reset();
    while (cyc < 9) begin
      if (cyc == 2) begin
        start = '1; periodic = '0;
        for (int i = 0; i < NT; i++) load_value[i*CW +: CW] = 8'd1;
      end
      advance();
    end
    total++;
    if (expired !== 4'b0001) begin
      bad++;
      $display("FAIL midscan_pre got=%b want=0001", expired);
    end
    reset = 1'b1;
    repeat (2) begin
      @(posedge clk); @(negedge clk);
      total++;
      if ({active, expired, tick, scan_busy} !== '0) begin
        bad++;
        $display("FAIL midscan_in_reset got=%b want=0", {active, expired, tick, scan_busy});
      end
    end
    reset = 1'b0;
    model_clear();
    while (cyc < 20) begin
      advance();
      total++;
      if ({active, expired, tick, scan_busy} !== {NT'(0), NT'(0), m_tick(), m_busy()}) begin
        bad++;
        $display("FAIL midscan_after c=%0d got=%b", cyc, {active, expired, tick, scan_busy});
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    repeat (400) begin
      for (int i = 0; i < NT; i++) begin
        start[i]    = ($urandom_range(0, 5) == 0);
        stop[i]     = ($urandom_range(0, 11) == 0);
        periodic[i] = $urandom_range(0, 1) == 1;
        load_value[i*CW +: CW] = CW'($urandom_range(0, 3));
      end
      advance();
      total++;
      if ({active, expired, tick, scan_busy} !== {m_act, m_exp, m_tick(), m_busy()}) begin
        bad++;
        $display("FAIL random c=%0d got=%b want=%b", cyc,
                 {active, expired, tick, scan_busy}, {m_act, m_exp, m_tick(), m_busy()});
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_oneshot();
    test_periodic_stop();
    test_edges();
    test_simultaneous();
    test_reset_midscan();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
